// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : calc_pkg
// Purpose  : Shared definitions for the calculator arithmetic controller.
//            Operation codes are also used by the calculator top-level FSM.
// Revision : 1.0 - initial release
// ============================================================================
package calc_pkg;

    // Operation encodings presented on the op port.
    localparam logic [1:0] OP_PLUS     = 2'd0;
    localparam logic [1:0] OP_MINUS    = 2'd1;
    localparam logic [1:0] OP_MULTIPLY = 2'd2;
    localparam logic [1:0] OP_DIVIDE   = 2'd3;

    // Iterative core modes.
    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDSUB = 3'd1,
        ST_MUL    = 3'd2,
        ST_DIV    = 3'd3,
        ST_FAULT  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/calc_iter_core.sv
`default_nettype none
// ============================================================================
// Module   : calc_iter_core
// Purpose  : Shared iterative datapath: LSB-first shift-add multiply and
//            MSB-first restoring divide, one step per enabled clock.
// Ports    : clk, rst_n      - clock, async active-low reset
//            clr             - synchronous clear of all state
//            mode            - MODE_MUL / MODE_DIV (sampled on load and step)
//            load            - capture operands and restart the counter
//            step            - perform one iteration
//            arg_a, arg_b    - operands captured on load
//            last_step       - counter is on its final iteration
//            acc_next        - accumulator after the current step (product)
//            mq_next         - multiplier/quotient after the current step
// Revision : 1.0 - initial release
// ============================================================================
module calc_iter_core
    import calc_pkg::*;
#(
    parameter int WIDTH = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               mode,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   arg_a,
    input  logic [WIDTH-1:0]   arg_b,
    output logic               last_step,
    output logic [2*WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0]   mq_next
);

    localparam int              CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] acc;      // product accumulator / partial remainder
    logic [WIDTH-1:0]   mq;       // multiplier (shifts right) / dividend->quotient
    logic [2*WIDTH-1:0] opd;      // multiplicand (shifts left) / divisor
    logic [2*WIDTH-1:0] opd_next;
    logic [WIDTH:0]     trial;    // remainder minus divisor, MSB is borrow
    logic [CW-1:0]      cnt;

    assign last_step = (cnt == LAST);

    always_comb begin
        acc_next = acc;
        mq_next  = mq;
        opd_next = opd;
        trial    = '0;
        if (mode == MODE_MUL) begin
            acc_next = acc + (mq[0] ? opd : '0);
            mq_next  = mq >> 1;
            opd_next = opd << 1;
        end else begin
            // Bring down the next dividend bit and try to subtract.
            // The remainder stays below the divisor, so W bits suffice after
            // a successful subtract and also when the subtract is rejected.
            trial = {acc[WIDTH-1:0], mq[WIDTH-1]} - {1'b0, opd[WIDTH-1:0]};
            if (!trial[WIDTH]) begin
                acc_next = {{WIDTH{1'b0}}, trial[WIDTH-1:0]};
                mq_next  = {mq[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {{WIDTH{1'b0}}, acc[WIDTH-2:0], mq[WIDTH-1]};
                mq_next  = {mq[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            mq  <= '0;
            opd <= '0;
            cnt <= '0;
        end else if (clr) begin
            acc <= '0;
            mq  <= '0;
            opd <= '0;
            cnt <= '0;
        end else if (load) begin
            acc <= '0;
            mq  <= (mode == MODE_DIV) ? arg_a : arg_b;
            opd <= {{WIDTH{1'b0}}, ((mode == MODE_DIV) ? arg_b : arg_a)};
            cnt <= '0;
        end else if (step) begin
            acc <= acc_next;
            mq  <= mq_next;
            opd <= opd_next;
            cnt <= last_step ? '0 : cnt + CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/calc_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : calc_alu_sequencer
// Purpose  : Multi-cycle arithmetic controller with start/done handshake.
//            Plus/minus finish in one step; multiply and divide iterate
//            WIDTH steps on calc_iter_core. Divide by zero reports div0.
// Ports    : clk, rst_n      - clock, async active-low reset
//            clr             - synchronous abort/clear (beats start)
//            start, op       - request and operation code
//            arg_a, arg_b    - operands, latched with start
//            busy, done      - in-progress flag, one-cycle completion pulse
//            result, ovf     - registered result and carry/borrow/overflow
//            div0            - last operation was a divide by zero
// Revision : 1.0 - initial release
// ============================================================================
module calc_alu_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] arg_a,
    input  logic [WIDTH-1:0] arg_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             div0
);

    state_t             state, state_n;
    logic               busy_n, done_n, ovf_n, div0_n;
    logic [WIDTH-1:0]   result_n;
    logic [1:0]         op_l;
    logic [WIDTH-1:0]   a_l, b_l;
    logic               accept;
    logic               core_mode, core_step, last_step;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mq_next;
    logic [WIDTH:0]     sum, diff;

    assign accept    = (state == ST_IDLE) && start && !clr;
    assign core_mode = accept ? ((op == OP_DIVIDE) ? MODE_DIV : MODE_MUL)
                              : ((state == ST_DIV) ? MODE_DIV : MODE_MUL);
    assign core_step = ((state == ST_MUL) || (state == ST_DIV)) && !clr;
    assign sum       = {1'b0, a_l} + {1'b0, b_l};
    // MSB of the extended difference is the borrow, i.e. a < b.
    assign diff      = {1'b0, a_l} - {1'b0, b_l};

    calc_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .mode      (core_mode),
        .load      (accept),
        .step      (core_step),
        .arg_a     (arg_a),
        .arg_b     (arg_b),
        .last_step (last_step),
        .acc_next  (acc_next),
        .mq_next   (mq_next)
    );

    always_comb begin
        state_n  = state;
        busy_n   = busy;
        done_n   = 1'b0;
        result_n = result;
        ovf_n    = ovf;
        div0_n   = div0;
        if (clr) begin
            state_n  = ST_IDLE;
            busy_n   = 1'b0;
            result_n = '0;
            ovf_n    = 1'b0;
            div0_n   = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy_n = 1'b1;
                        case (op)
                            OP_PLUS, OP_MINUS: state_n = ST_ADDSUB;
                            OP_MULTIPLY:       state_n = ST_MUL;
                            default:           state_n = (arg_b == '0) ? ST_FAULT : ST_DIV;
                        endcase
                    end
                end
                ST_ADDSUB: begin
                    result_n = (op_l == OP_MINUS) ? diff[WIDTH-1:0] : sum[WIDTH-1:0];
                    ovf_n    = (op_l == OP_MINUS) ? diff[WIDTH] : sum[WIDTH];
                    div0_n   = 1'b0;
                    done_n   = 1'b1;
                    busy_n   = 1'b0;
                    state_n  = ST_IDLE;
                end
                ST_MUL: begin
                    if (last_step) begin
                        result_n = acc_next[WIDTH-1:0];
                        ovf_n    = |acc_next[2*WIDTH-1:WIDTH];
                        div0_n   = 1'b0;
                        done_n   = 1'b1;
                        busy_n   = 1'b0;
                        state_n  = ST_IDLE;
                    end
                end
                ST_DIV: begin
                    if (last_step) begin
                        result_n = mq_next;
                        ovf_n    = 1'b0;
                        div0_n   = 1'b0;
                        done_n   = 1'b1;
                        busy_n   = 1'b0;
                        state_n  = ST_IDLE;
                    end
                end
                ST_FAULT: begin
                    result_n = '0;
                    ovf_n    = 1'b0;
                    div0_n   = 1'b1;
                    done_n   = 1'b1;
                    busy_n   = 1'b0;
                    state_n  = ST_IDLE;
                end
                default: begin
                    state_n = ST_IDLE;
                    busy_n  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            ovf    <= 1'b0;
            div0   <= 1'b0;
            op_l   <= OP_PLUS;
            a_l    <= '0;
            b_l    <= '0;
        end else begin
            state  <= state_n;
            busy   <= busy_n;
            done   <= done_n;
            result <= result_n;
            ovf    <= ovf_n;
            div0   <= div0_n;
            if (accept) begin
                op_l <= op;
                a_l  <= arg_a;
                b_l  <= arg_b;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_calc_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_alu_sequencer
// Purpose  : Self-checking bench for calc_alu_sequencer: a transaction-level
//            model compared every cycle, plus directed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc_alu_sequencer;

    localparam int WIDTH = 14;
    localparam int MOD   = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst_n, clr, start;
    logic [1:0]       op;
    logic [WIDTH-1:0] arg_a, arg_b;
    logic             busy, done, ovf, div0;
    logic [WIDTH-1:0] result;

    int total = 0;
    int bad   = 0;

    calc_alu_sequencer #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .start  (start),
        .op     (op),
        .arg_a  (arg_a),
        .arg_b  (arg_b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .ovf    (ovf),
        .div0   (div0)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // Tracks only "edges remaining until done" and the arithmetic answer.
    logic m_busy, m_done, m_ovf, m_div0;
    int   m_result, m_left, p_res;
    logic p_ovf, p_div0;

    always @(posedge clk or negedge rst_n) begin
        int x, y, s;
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_ovf = 0; m_div0 = 0; m_result = 0; m_left = 0;
        end else begin
            m_done = 0;
            if (clr) begin
                m_busy = 0; m_ovf = 0; m_div0 = 0; m_result = 0; m_left = 0;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0; m_done = 1;
                    m_result = p_res; m_ovf = p_ovf; m_div0 = p_div0;
                end
            end else if (start) begin
                x = int'(arg_a); y = int'(arg_b);
                m_busy = 1; p_ovf = 0; p_div0 = 0;
                case (op)
                    2'd0: begin s = x + y; p_res = s % MOD; p_ovf = (s >= MOD); m_left = 1; end
                    2'd1: begin p_res = (x - y + MOD) % MOD; p_ovf = (x < y); m_left = 1; end
                    2'd2: begin s = x * y; p_res = s % MOD; p_ovf = (s >= MOD); m_left = WIDTH; end
                    default: begin
                        if (y == 0) begin p_res = 0; p_div0 = 1; m_left = 1; end
                        else begin p_res = x / y; m_left = WIDTH; end
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        check("cyc_busy",   busy,   m_busy);
        check("cyc_done",   done,   m_done);
        check("cyc_result", result, m_result);
        check("cyc_ovf",    ovf,    m_ovf);
        check("cyc_div0",   div0,   m_div0);
    end

    // ---------------- directed stimulus ----------------
    task automatic run_op(input logic [1:0] o, input int x, input int y,
                          input int exp_r, input int exp_ovf, input int exp_d0, input int exp_lat);
        int lat;
        op = o; arg_a = WIDTH'(x); arg_b = WIDTH'(y); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_accept", busy, 1);
        arg_a = ~arg_a; arg_b = ~arg_b;  // later operand changes must not matter
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, exp_lat);
        check("result", result, exp_r);
        check("ovf", ovf, exp_ovf);
        check("div0", div0, exp_d0);
        check("busy_at_done", busy, 0);
    endtask

    initial begin
        int lat, nd;
        rst_n = 1'b0; clr = 1'b0; start = 1'b0; op = 2'd0; arg_a = '0; arg_b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_ovf", ovf, 0);
        check("rst_div0", div0, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(2'd0, 123,   456,  579,   0, 0, 1);
        run_op(2'd1, 5,     7,    16382, 1, 0, 1);
        run_op(2'd2, 99,    99,   9801,  0, 0, 14);
        run_op(2'd2, 200,   100,  3616,  1, 0, 14);
        run_op(2'd3, 1000,  7,    142,   0, 0, 14);
        run_op(2'd3, 5,     0,    0,     0, 1, 1);
        run_op(2'd0, 16383, 1,    0,     1, 0, 1);
        run_op(2'd3, 16383, 1,    16383, 0, 0, 14);
        run_op(2'd2, 16383, 16383, 1,    1, 0, 14);

        // Multiply with an ignored start mid-flight, then back-to-back PLUS.
        op = 2'd2; arg_a = 14'd12; arg_b = 14'd12; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        op = 2'd0; arg_a = 14'd1000; arg_b = 14'd1000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("mul12_result", result, 144);
        check("mul12_latency", lat, 11);
        op = 2'd0; arg_a = 14'd1; arg_b = 14'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", busy, 1);
        @(negedge clk);
        check("b2b_done", done, 1);
        check("b2b_result", result, 2);

        // Asynchronous reset in the middle of a multiply.
        op = 2'd2; arg_a = 14'd50; arg_b = 14'd50; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(2'd0, 2, 3, 5, 0, 0, 1);

        // Clear part-way through a divide.
        op = 2'd3; arg_a = 14'd9999; arg_b = 14'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_busy", busy, 0);
        check("clr_result", result, 0);
        nd = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("clr_no_done", nd, 0);

        // clr and start together: the request is dropped.
        op = 2'd0; arg_a = 14'd7; arg_b = 14'd7; clr = 1'b1; start = 1'b1;
        @(negedge clk);
        clr = 1'b0; start = 1'b0;
        check("clrstart_busy", busy, 0);
        nd = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("clrstart_no_done", nd, 0);
        run_op(2'd0, 7, 7, 14, 0, 0, 1);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/calc_alu_sequencer.md
Name: calc_alu_sequencer

Overview:
Multi-cycle arithmetic controller for the keypad calculator. It accepts one operation (plus, minus, multiply, divide) on two unsigned operands through a start/done handshake. Plus and minus complete in a single step; multiply (shift-add) and divide (restoring) run on a shared iterative datapath for WIDTH steps. It sits between the calculator FSM's calculate state and reg_result, replacing the single-cycle multiplier and providing the divide operation.

Parameters:
WIDTH, 14, operand/result width in bits; also the iteration count for multiply and divide.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous abort/clear; priority over start
start  input  1  request; sampled only while busy=0
op  input  2  0=PLUS, 1=MINUS, 2=MULTIPLY, 3=DIVIDE; latched with start
arg_a  input  WIDTH  left operand (accumulator); latched with start
arg_b  input  WIDTH  right operand; latched with start
busy  output  1  high from the edge after start is accepted until the completing edge
done  output  1  one-cycle completion pulse
result  output  WIDTH  registered result; held until the next completion or clear
ovf  output  1  carry / borrow / product overflow of the last operation
div0  output  1  last operation was a divide by zero

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy, done, ovf and div0 = 0; result=0; iteration counter=0. Reset mid-operation abandons the operation and produces no done.
- States: IDLE, ADDSUB, MUL, DIV, FAULT.
- IDLE: if start=1 at edge k (and clr=0), latch op, arg_a and arg_b, set busy=1, then go to:
  - ADDSUB for op 0 or 1
  - MUL for op 2
  - DIV for op 3 with arg_b != 0
  - FAULT for op 3 with arg_b == 0
- Operand changes after edge k have no effect on the operation.
- ADDSUB, at edge k+1:
  - PLUS: result = (a+b) mod 2^WIDTH; ovf = carry out.
  - MINUS: result = (a-b) mod 2^WIDTH; ovf = (a<b).
  - Also: div0=0, done=1, busy=0, next state IDLE.
- MUL:
  - Internal 2*WIDTH-bit accumulator; counter runs 0..WIDTH-1, one shift-add step per edge, LSB-first over b.
  - On the edge where counter=WIDTH-1 (edge k+WIDTH): result = low WIDTH bits of the product; ovf = (high WIDTH bits != 0); done=1, busy=0, next state IDLE.
- DIV:
  - Restoring division, one quotient bit per edge, MSB-first; counter runs 0..WIDTH-1.
  - At edge k+WIDTH: result = floor(a/b); remainder discarded; ovf=0; div0=0; done=1; busy=0; next state IDLE.
- FAULT, at edge k+1: result=0, ovf=0, div0=1, done=1, busy=0, next state IDLE.
- Latency from the accepting edge k to done high:
  - 1 edge for add/sub and FAULT
  - WIDTH edges for mul/div (14 at default)
- done:
  - High for exactly one cycle; falls at the next edge unless another completion occurs.
  - result, ovf and div0 change only on completing edges or clr.
- Back-to-back: start asserted in the cycle where done=1 (state IDLE) is accepted; zero bubble.
- start while busy=1 is ignored and not queued.
- clr=1 at any edge (any state):
  - Effects: state=IDLE, busy=0, done=0, result=0, ovf=0, div0=0, counter=0.
  - An in-flight operation is abandoned with no done.
  - clr and start in the same edge: clr wins and start is dropped.
- All arithmetic is unsigned, with wrap modulo 2^WIDTH as stated above.

Decomposition:
- Package calc_pkg holds:
  - op encodings OP_PLUS, OP_MINUS, OP_MULTIPLY, OP_DIVIDE (2-bit)
  - the state enum for IDLE, ADDSUB, MUL, DIV, FAULT
  - the OP_* constants are shared with the calculator top-level FSM
- One sub-module is natural: calc_iter_core, the shared shift-add/restoring-subtract step datapath.
  - Inputs: mode, load, step.
  - It holds the accumulator, the quotient/multiplier register and the counter.
  - It reports last_step to the sequencer FSM.

Test Plan:
- PLUS a=123, b=456, start at edge k -> done=1 after edge k+1; result=579, ovf=0. MINUS a=5, b=7 -> result=16382, ovf=1.
- MULTIPLY a=99, b=99 -> busy for 14 cycles, done after edge k+14; result=9801, ovf=0. MULTIPLY a=200, b=100 -> result=3616, ovf=1.
- DIVIDE a=1000, b=7 -> done after edge k+14, result=142. DIVIDE a=5, b=0 -> done after edge k+1; result=0, div0=1.
- MULTIPLY 12*12 accepted; start with PLUS pulsed at iteration 3 is ignored. Then start PLUS 1+1 in the done cycle -> result=144 then 2; done pulses on consecutive operations with no bubble.
- clr at iteration 5 of DIVIDE 9999/3 -> next cycle busy=0, result=0, no done ever. Simultaneous clr+start -> nothing accepted.
- rst_n low mid-MULTIPLY -> busy, done and result go to 0 asynchronously. After release, PLUS 2+3 -> result=5.
